// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: RV32I byte/half/word accesses mapped onto a word-only datmem.
// Optional macro MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of ignoring low address bits.
//   state | meaning
//   IDLE  | ready for a request
//   RD    | read issued to datmem (load or sub-word store)
//   LDR   | read data returned, extended load response
//   MRG   | merge store lane into read word
//   WR    | datmem write, store response
//   ERR   | error response, no datmem access
module mem_access_unit #(
  parameter int          WORDS    = 64,
  parameter logic [31:0] MEM_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign,
  output logic        oob,
  output logic [31:0] mem_ad,
  output logic [31:0] writ_dat,
  output logic        mem_wrt,
  input  logic [31:0] red_dat
);

  typedef enum logic [2:0] {IDLE, RD, LDR, MRG, WR, ERR} state_t;

  localparam logic [29:0] WORDS_W = 30'(WORDS);

  state_t      state, nxt;
  logic        we_q, oob_q, mis_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [29:0] word_q;
  logic [15:0] wdata_q;
  logic [31:0] wr_word;

  logic [29:0] word_idx;
  logic        is_oob, legal, mis, acc_err, accept;
  logic [31:0] merged, load_data;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign word_idx = 30'((req_addr - MEM_BASE) >> 2);
  assign is_oob   = word_idx >= WORDS_W;
  assign accept   = (state == IDLE) && req_valid;

  always_comb begin
    legal = 1'b0;
    if (req_we) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else        legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
  end

`ifdef MISALIGN_TRAP_EN
  assign mis = legal && (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign acc_err = !legal || is_oob || mis;

  // Lane extraction and merge share the latched lane select.
  assign sel_b = red_dat[{lane_q, 3'b000} +: 8];
  assign sel_h = lane_q[1] ? red_dat[31:16] : red_dat[15:0];

  always_comb begin
    merged = red_dat;
    if (f3_q[1:0] == 2'b00)      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else if (f3_q[1:0] == 2'b01) merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    case (f3_q)
      3'b000:  load_data = {{24{sel_b[7]}}, sel_b};
      3'b001:  load_data = {{16{sel_h[15]}}, sel_h};
      3'b100:  load_data = {24'h0, sel_b};
      3'b101:  load_data = {16'h0, sel_h};
      default: load_data = red_dat;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (req_valid) begin
        if (acc_err)                    nxt = ERR;
        else if (!req_we)               nxt = RD;
        else if (req_funct3 == 3'b010)  nxt = WR;
        else                            nxt = RD;
      end
      RD:      nxt = we_q ? MRG : LDR;
      MRG:     nxt = WR;
      LDR:     nxt = IDLE;
      WR:      nxt = IDLE;
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == LDR) || (state == WR) || (state == ERR);
    rsp_rdata = (state == LDR) ? load_data : 32'h0;
    mem_wrt   = (state == WR);
    writ_dat  = (state == WR) ? wr_word : 32'h0;
    mem_ad    = (state == IDLE) ? 32'h0 : {word_q, 2'b00};
    oob       = (state == ERR) && oob_q;
    misalign  = (state == ERR) && mis_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
      word_q  <= 30'h0;
      wdata_q <= 16'h0;
      wr_word <= 32'h0;
      oob_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      lane_q  <= req_addr[1:0];
      word_q  <= word_idx;
      wdata_q <= req_wdata[15:0];
      wr_word <= req_wdata;
      oob_q   <= is_oob && legal;
      mis_q   <= mis;
    end else if (state == MRG) begin
      wr_word <= merged;
    end
  end

endmodule
